// File: rtl/spi_frame_writer_pkg.sv
// rtl/spi_frame_writer_pkg.sv - shared types and defaults for the SPI pixel writer
// Holds the writer FSM state type, the pixel/address width defaults shared with
// the display controller and pixel RAM, and the colour field bit positions.
package spi_frame_writer_pkg;

  localparam int PIXEL_BITS_DEF = 16;
  localparam int ADDR_BITS_DEF  = 11;

  // RGB444x pixel layout; the low nibble is unused.
  localparam int RED_MSB = 15;
  localparam int RED_LSB = 12;
  localparam int GRN_MSB = 11;
  localparam int GRN_LSB = 8;
  localparam int BLU_MSB = 7;
  localparam int BLU_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    FLIP_PENDING
  } state_t;

endpackage

// File: rtl/spi_frame_writer_sync_edge.sv
// rtl/spi_frame_writer_sync_edge.sv - N-stage synchroniser with rise/fall detect
// Ports:
//   clk, n_reset : system clock, synchronous active-low reset
//   async_in     : asynchronous input
//   level        : synchronised level
//   rise, fall   : one-cycle pulses on synchronised edges
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_frame_writer.sv
// rtl/spi_frame_writer.sv - SPI-fed pixel RAM writer with double-buffer flip
// Ports:
//   clk, n_reset            : system clock, synchronous active-low reset
//   spi_clk/mosi/cs_n       : asynchronous SPI mode-0 slave inputs, MSB first
//   frame_start             : display side begins scanning a new frame
//   wr_en/wr_addr/wr_data   : pixel RAM write port
//   wr_buffer               : buffer being written; display_buffer is its inverse
//   frame_done              : pulse when the buffers flip
//   overrun                 : sticky, a word was dropped while a flip was pending
//   busy                    : receiving or waiting for the flip
module spi_frame_writer
  import spi_frame_writer_pkg::*;
#(
  parameter int PIXEL_BITS  = PIXEL_BITS_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  input  logic                  frame_start,
  output logic                  wr_en,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [PIXEL_BITS-1:0] wr_data,
  output logic                  wr_buffer,
  output logic                  display_buffer,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  busy
);

  localparam int                 CNT_BITS = $clog2(PIXEL_BITS);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(PIXEL_BITS - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};

  logic cs_level, cs_rise, cs_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  // cs_n idles high, so its synchroniser resets high to avoid a false edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .n_reset(n_reset), .async_in(spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .n_reset(n_reset), .async_in(spi_clk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .n_reset(n_reset), .async_in(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the SPI clock rising edge and the data level matter for mode 0.
  logic unused_edges;
  assign unused_edges = sclk_level ^ sclk_fall ^ mosi_rise ^ mosi_fall;

  state_t                  state_q, state_d;
  logic [CNT_BITS-1:0]     bit_cnt;
  logic [PIXEL_BITS-1:0]   shift_q;
  logic                    cs_active;
  logic                    capture;
  logic                    word_done;
  logic                    flip;
  logic [PIXEL_BITS-1:0]   next_word;

  assign cs_active = ~cs_level;
  assign capture   = sclk_rise & cs_active & (state_q != IDLE);
  assign word_done = capture & (bit_cnt == CNT_LAST);
  assign next_word = {shift_q[PIXEL_BITS-2:0], mosi_level};

  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    flip    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = RECEIVE;
      end
      RECEIVE: begin
        if (cs_rise)                             state_d = IDLE;
        else if (wr_en && (wr_addr == ADDR_LAST)) state_d = FLIP_PENDING;
      end
      FLIP_PENDING: begin
        // CS edges are ignored here; the CS level picks the post-flip state.
        if (frame_start) begin
          flip    = 1'b1;
          state_d = cs_active ? RECEIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_buffer  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      if (capture) begin
        shift_q <= next_word;
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (word_done) begin
        if (state_q == RECEIVE) begin
          wr_en   <= 1'b1;
          wr_data <= next_word;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (wr_en) wr_addr <= wr_addr + 1'b1;

      // Later assignments take priority over the capture/advance above.
      if ((state_q == IDLE && cs_fall) || (state_q == RECEIVE && cs_rise)) begin
        bit_cnt <= '0;
        wr_addr <= '0;
      end

      if (flip) begin
        wr_buffer  <= ~wr_buffer;
        frame_done <= 1'b1;
        wr_addr    <= '0;
        bit_cnt    <= '0;
      end
    end
  end

  assign display_buffer = ~wr_buffer;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_writer.sv
// tb/tb_spi_frame_writer.sv - self-checking bench for spi_frame_writer
module tb_spi_frame_writer;

  localparam int AB    = 7;
  localparam int FRAME = 1 << AB;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          frame_start = 1'b0;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_buffer;
  logic          display_buffer;
  logic          frame_done;
  logic          overrun;
  logic          busy;

  spi_frame_writer #(.PIXEL_BITS(16), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .clk(clk), .n_reset(n_reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_buffer(wr_buffer),
    .display_buffer(display_buffer), .frame_done(frame_done),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [15:0]   data;
    logic          bufsel;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  fd_count = 0;

  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (wr_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || wr_buffer !== e.bufsel) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%h buf=%0b, required addr=%0d data=%h buf=%0b",
                   wr_addr, wr_data, wr_buffer, e.addr, e.data, e.bufsel);
        end
      end
    end
  end

  task automatic push_exp(input int a, input logic [15:0] d, input logic b);
    wr_t e;
    e.addr = AB'(a);
    e.data = d;
    e.bufsel = b;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    repeat (2) @(negedge clk);
    spi_clk = 1'b1;
    repeat (2) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (display_buffer !== 1'b1) begin n_fail++; $display("FAIL reset_display_buffer: got %0b required 1", display_buffer); end
    n_checks++; if (wr_buffer !== 1'b0) begin n_fail++; $display("FAIL reset_wr_buffer: got %0b required 0", wr_buffer); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b required 0", overrun); end
    n_checks++; if (wr_addr !== '0 || wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_wr_port: got addr=%0d data=%h required 0/0000", wr_addr, wr_data); end
  endtask

  task automatic test_two_words();
    cs_low();
    push_exp(0, 16'hF0A5, 1'b0);
    push_exp(1, 16'h1234, 1'b0);
    send_word(16'hF0A5);
    send_word(16'h1234);
    repeat (6) @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL two_words_drain: got %0d pending required 0", sb.size()); end
    n_checks++; if (wr_addr !== AB'(2)) begin n_fail++; $display("FAIL two_words_addr: got %0d required 2", wr_addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL two_words_busy: got %0b required 1", busy); end
    pulse_fs();
    repeat (2) @(negedge clk);
    n_checks++; if (fd_count != 0 || wr_buffer !== 1'b0) begin n_fail++; $display("FAIL fs_ignored: got frame_done count=%0d buf=%0b required 0/0", fd_count, wr_buffer); end
    cs_high();
  endtask

  task automatic test_full_frame();
    cs_low();
    for (int a = 0; a < FRAME; a++) begin
      push_exp(a, 16'(a), 1'b0);
      send_word(16'(a));
    end
    repeat (6) @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL frame_drain: got %0d pending required 0", sb.size()); end
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_pending: got %0b required 1", busy); end
    n_checks++; if (fd_count != 0 || wr_buffer !== 1'b0) begin n_fail++; $display("FAIL early_flip: got count=%0d buf=%0b required 0/0", fd_count, wr_buffer); end
    pulse_fs();
    repeat (2) @(negedge clk);
    n_checks++; if (fd_count != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d required 1", fd_count); end
    n_checks++; if (wr_buffer !== 1'b1 || display_buffer !== 1'b0) begin n_fail++; $display("FAIL flip_buffers: got wr=%0b disp=%0b required 1/0", wr_buffer, display_buffer); end
    n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL flip_addr: got %0d required 0", wr_addr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flip_cs_active_busy: got %0b required 1", busy); end
  endtask

  task automatic test_overrun();
    for (int a = 0; a < FRAME; a++) begin
      push_exp(a, 16'(a) ^ 16'hA5A5, 1'b1);
      send_word(16'(a) ^ 16'hA5A5);
    end
    repeat (6) @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %0b required 0", overrun); end
    for (int i = 0; i < 3; i++) send_word(16'hC0DE + 16'(i));
    repeat (6) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0b required 1", overrun); end
    n_checks++; if (fd_count != 1) begin n_fail++; $display("FAIL overrun_no_flip: got %0d required 1", fd_count); end
    pulse_fs();
    repeat (2) @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %0b required 1", overrun); end
    n_checks++; if (fd_count != 2 || wr_buffer !== 1'b0) begin n_fail++; $display("FAIL second_flip: got count=%0d buf=%0b required 2/0", fd_count, wr_buffer); end
    cs_high();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_cs: got %0b required 0", busy); end
  endtask

  task automatic test_abort();
    cs_low();
    for (int i = 0; i < 100; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      push_exp(i, d, 1'b0);
      send_word(d);
    end
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    cs_high();
    cs_low();
    push_exp(0, 16'hBEEF, 1'b0);
    send_word(16'hBEEF);
    repeat (6) @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL abort_drain: got %0d pending required 0", sb.size()); end
    n_checks++; if (fd_count != 2 || wr_buffer !== 1'b0) begin n_fail++; $display("FAIL abort_no_flip: got count=%0d buf=%0b required 2/0", fd_count, wr_buffer); end
    cs_high();
  endtask

  task automatic test_reset_mid_word();
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n_reset = 1'b0;
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 16'h0) begin n_fail++; $display("FAIL midreset_wr_port: got en=%0b addr=%0d data=%h required 0/0/0000", wr_en, wr_addr, wr_data); end
    n_checks++; if (wr_buffer !== 1'b0 || display_buffer !== 1'b1) begin n_fail++; $display("FAIL midreset_buffers: got wr=%0b disp=%0b required 0/1", wr_buffer, display_buffer); end
    n_checks++; if (overrun !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got ovr=%0b busy=%0b fd=%0b required 0/0/0", overrun, busy, frame_done); end
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    cs_low();
    push_exp(0, 16'h5A3C, 1'b0);
    send_word(16'h5A3C);
    repeat (6) @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL post_reset_write: got %0d pending required 0", sb.size()); end
    cs_high();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_two_words();
    test_full_frame();
    test_overrun();
    test_abort();
    test_reset_mid_word();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
